// File: rtl/exp_taylor_sequencer.sv
// exp(x) Taylor-series sequencer that time-shares one external pipelined multiplier.
// Define EXP_SATURATE_EN to saturate truncated products and the accumulator add.
package cnn1d_pkg;

    localparam int DATA_WIDTH          = 12;
    localparam int FRACTION            = 6;
    localparam int LPM_OUT_WIDTH       = 2 * DATA_WIDTH;
    localparam int LPM_OUT_MSB         = FRACTION + DATA_WIDTH - 1;
    localparam int LPM_PIPE_WIDTH      = 4;
    localparam int SUPPORTED_PRECISION = 6;

    localparam int FACTORIAL_0 = 1;
    localparam int FACTORIAL_1 = 1;
    localparam int FACTORIAL_2 = 2;
    localparam int FACTORIAL_3 = 6;
    localparam int FACTORIAL_4 = 24;
    localparam int FACTORIAL_5 = 120;
    localparam int FACTORIAL_6 = 720;

    function automatic int factorial(input int k);
        int f;
        f = FACTORIAL_0;
        unique case (k)
            1:       f = FACTORIAL_1;
            2:       f = FACTORIAL_2;
            3:       f = FACTORIAL_3;
            4:       f = FACTORIAL_4;
            5:       f = FACTORIAL_5;
            6:       f = FACTORIAL_6;
            default: f = FACTORIAL_0;
        endcase
        return f;
    endfunction

    // Rounded 1/k! in the fixed-point format.
    function automatic int inv_fact(input int k);
        return (2 ** FRACTION + factorial(k) / 2) / factorial(k);
    endfunction

endpackage

module exp_taylor_sequencer
    import cnn1d_pkg::*;
#(
    parameter int TERMS        = 4,
    parameter int MULT_LATENCY = LPM_PIPE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     mult_valid,
    output logic [DATA_WIDTH-1:0]    mult_a,
    output logic [DATA_WIDTH-1:0]    mult_b,
    input  logic [LPM_OUT_WIDTH-1:0] mult_result,
    output logic                     busy
);

    localparam int DW = DATA_WIDTH;
    localparam int LW = LPM_OUT_WIDTH;
    localparam int KW = $clog2(SUPPORTED_PRECISION + 1);
    localparam int CW = $clog2(MULT_LATENCY + 1);

    localparam logic [DW-1:0] ONE = DW'(2 ** FRACTION);

    localparam logic [DW-1:0] INV_FACT [8] = '{
        '0,
        DW'(inv_fact(1)),
        DW'(inv_fact(2)),
        DW'(inv_fact(3)),
        DW'(inv_fact(4)),
        DW'(inv_fact(5)),
        DW'(inv_fact(6)),
        '0
    };

    if (TERMS < 1 || TERMS > SUPPORTED_PRECISION) begin : g_bad_terms
        $error("exp_taylor_sequencer: TERMS out of range");
    end

`ifdef EXP_SATURATE_EN
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
`endif

    function automatic logic [DW-1:0] trunc_p(input logic [LW-1:0] r);
`ifdef EXP_SATURATE_EN
        logic [LW-LPM_OUT_MSB-1:0] hi;
        hi = r[LW-1:LPM_OUT_MSB];
        if (hi == '0 || hi == '1) begin
            return r[LPM_OUT_MSB -: DW];
        end
        return r[LW-1] ? SMIN : SMAX;
`else
        return r[LPM_OUT_MSB -: DW];
`endif
    endfunction

    function automatic logic [DW-1:0] add_w(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
`ifdef EXP_SATURATE_EN
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1]) begin
            return s[DW] ? SMIN : SMAX;
        end
        return s[DW-1:0];
`else
        return a + b;
`endif
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        POW_ISSUE,
        POW_WAIT,
        SCL_ISSUE,
        SCL_WAIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] pow_q, pow_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] out_q, out_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] p;
    logic [DW-1:0] sum;
    logic          unused_bits;

    assign p   = trunc_p(mult_result);
    assign sum = add_w(acc_q, p);

    assign unused_bits = ^{mult_result[FRACTION-1:0],
                           mult_result[LW-1:LPM_OUT_MSB]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            pow_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            pow_q   <= pow_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands are registered on the transition into an issue state,
    // so they are stable during the strobe and held afterwards.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        pow_d   = pow_q;
        acc_d   = acc_q;
        out_d   = out_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    pow_d   = ONE;
                    acc_d   = ONE;
                    k_d     = KW'(1);
                    a_d     = ONE;
                    b_d     = in_data;
                    state_d = POW_ISSUE;
                end
            end
            POW_ISSUE: begin
                cnt_d   = CW'(MULT_LATENCY);
                state_d = POW_WAIT;
            end
            POW_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    pow_d   = p;
                    a_d     = p;
                    b_d     = INV_FACT[k_q];
                    state_d = SCL_ISSUE;
                end
            end
            SCL_ISSUE: begin
                cnt_d   = CW'(MULT_LATENCY);
                state_d = SCL_WAIT;
            end
            SCL_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    acc_d = sum;
                    if (k_q == KW'(TERMS)) begin
                        out_d   = sum;
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        a_d     = pow_q;
                        b_d     = x_q;
                        state_d = POW_ISSUE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE) && !rst;
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_data   = out_q;
    assign mult_valid = (state_q == POW_ISSUE) || (state_q == SCL_ISSUE);
    assign mult_a     = a_q;
    assign mult_b     = b_q;

endmodule
